// File: rtl/axis_histogram_pipe_pkg.sv
// axis_histogram_pipe_pkg: shared FSM state type for the streaming histogram
package axis_histogram_pipe_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
endpackage

// File: rtl/axis_histogram_pipe.sv
// axis_histogram_pipe: full-rate AXIS histogram over an external dual-port BRAM (A reads, B writes)
//   aclk/areset    clock and async active-high reset, passed through to both BRAM ports
//   cfg_clear      level, starts a clear sweep when sampled in RUN
//   sts_busy       high while draining or clearing
//   s_axis_*       sample stream, one sample per clock while tready
//   a_bram_*       read port, combinational address, rdata latency 1
//   b_bram_*       write port, registered address/data/strobe
module axis_histogram_pipe
  import axis_histogram_pipe_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 14,
  parameter int BIN_SHIFT = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic aclk,
  input  logic areset,
  input  logic cfg_clear,
  output logic sts_busy,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  output logic a_bram_clk,
  output logic a_bram_rst,
  output logic a_bram_en,
  output logic [BRAM_ADDR_WIDTH-1:0] a_bram_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] a_bram_rdata,
  output logic b_bram_clk,
  output logic b_bram_rst,
  output logic b_bram_en,
  output logic [BRAM_DATA_WIDTH/8-1:0] b_bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0] b_bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0] b_bram_wdata
);
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = BRAM_DATA_WIDTH;
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] x);
    return &x ? x : x + 1'b1;
  endfunction
  state_t state, state_nx;
  logic v1, wen, v3, last, unused_tdata;
  logic [AW-1:0] addr1, addr2, addr3;
  logic [DW-1:0] data2, data3, old;
  assign a_bram_clk = aclk;
  assign b_bram_clk = aclk;
  assign a_bram_rst = areset;
  assign b_bram_rst = areset;
  assign a_bram_en = s_axis_tvalid & s_axis_tready;
  assign a_bram_addr = s_axis_tdata[BIN_SHIFT +: AW];
  assign unused_tdata = ^s_axis_tdata;
  assign b_bram_en = wen;
  assign b_bram_we = {(DW/8){wen}};
  assign b_bram_addr = addr2;
  assign b_bram_wdata = data2;
  // wen doubles as the S2 valid; during CLEAR addr2 is the sweep counter
  assign last = wen & (&addr2);
  // S2 write is not yet in the BRAM; S3 write landed on the same edge as the read (stale on port A)
  assign old = (wen && addr2 == addr1) ? data2 : (v3 && addr3 == addr1) ? data3 : a_bram_rdata;
  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    else state <= state_nx;
  always_comb
    state_nx = (state == RUN) ? (cfg_clear ? DRAIN : RUN)
             : (state == DRAIN) ? ((~v1 & ~wen) ? CLEAR : DRAIN)
             : (last ? RUN : CLEAR);
  always_comb begin
    s_axis_tready = state == RUN;
    sts_busy = state != RUN;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      v1 <= 1'b0;
      wen <= 1'b0;
      v3 <= 1'b0;
      addr1 <= '0;
      addr2 <= '0;
      addr3 <= '0;
      data2 <= '0;
      data3 <= '0;
    end else begin
      v1 <= a_bram_en;
      addr1 <= a_bram_addr;
      wen <= (state == CLEAR) ? ~last : v1;
      addr2 <= (state == CLEAR) ? (wen ? addr2 + 1'b1 : '0) : addr1;
      data2 <= (state == CLEAR) ? '0 : sat_inc(old);
      v3 <= wen;
      addr3 <= addr2;
      data3 <= data2;
    end
endmodule

// File: tb/tb_axis_histogram_pipe.sv
// tb_axis_histogram_pipe: scoreboard bench with BRAM models for the streaming histogram
module tb_axis_histogram_pipe;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int N = 1 << AW;
  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic areset, cfg_clear, busy, tvalid, tready;
  logic [15:0] tdata;
  logic a_clk, a_rst, a_en, b_clk, b_rst, b_en;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_rdata, b_wdata;
  logic [3:0] b_we;
  logic [DW-1:0] mem0 [N];
  logic [DW-1:0] model [N];
  logic busy1, tvalid1, tready1;
  logic [15:0] tdata1;
  logic a1_clk, a1_rst, a1_en, b1_clk, b1_rst, b1_en;
  logic [3:0] a1_addr, b1_addr;
  logic [DW-1:0] a1_rdata, b1_wdata;
  logic [3:0] b1_we;
  logic [DW-1:0] mem1 [16];
  wr_t sb[$];
  wr_t e_wr;
  logic [AW-1:0] bin_i;
  int total = 0, bad = 0, clr_cnt = 0, first_clr = -1, stall_cnt = 0, timeouts = 0;

  axis_histogram_pipe dut (
    .aclk(clk), .areset(areset), .cfg_clear(cfg_clear), .sts_busy(busy),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .a_bram_clk(a_clk), .a_bram_rst(a_rst), .a_bram_en(a_en), .a_bram_addr(a_addr), .a_bram_rdata(a_rdata),
    .b_bram_clk(b_clk), .b_bram_rst(b_rst), .b_bram_en(b_en), .b_bram_we(b_we), .b_bram_addr(b_addr),
    .b_bram_wdata(b_wdata)
  );
  axis_histogram_pipe #(.BRAM_ADDR_WIDTH(4), .BIN_SHIFT(2), .CLEAR_ON_RESET(0)) dut1 (
    .aclk(clk), .areset(areset), .cfg_clear(1'b0), .sts_busy(busy1),
    .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1), .s_axis_tready(tready1),
    .a_bram_clk(a1_clk), .a_bram_rst(a1_rst), .a_bram_en(a1_en), .a_bram_addr(a1_addr), .a_bram_rdata(a1_rdata),
    .b_bram_clk(b1_clk), .b_bram_rst(b1_rst), .b_bram_en(b1_en), .b_bram_we(b1_we), .b_bram_addr(b1_addr),
    .b_bram_wdata(b1_wdata)
  );

  // read-first true dual-port RAMs
  always @(posedge a_clk) if (a_en) a_rdata <= mem0[a_addr];
  always @(posedge b_clk) if (b_en) for (int k = 0; k < 4; k++) if (b_we[k]) mem0[b_addr][8*k +: 8] <= b_wdata[8*k +: 8];
  always @(posedge a1_clk) if (a1_en) a1_rdata <= mem1[a1_addr];
  always @(posedge b1_clk) if (b1_en) for (int k = 0; k < 4; k++) if (b1_we[k]) mem1[b1_addr][8*k +: 8] <= b1_wdata[8*k +: 8];

  // scoreboard: accepted samples push their expected write; port-B writes pop it,
  // writes with nothing pending must be clear-sweep zeros
  always @(negedge clk) begin
    if (areset) sb.delete();
    else begin
      if (b_en) begin
        total++;
        if (sb.size() != 0) begin
          e_wr = sb.pop_front();
          if (b_addr !== e_wr.addr || b_wdata !== e_wr.data || b_we !== 4'hf) begin
            bad++;
            $display("FAIL sb_write: got addr=%0d data=%h we=%h, want addr=%0d data=%h we=f", b_addr, b_wdata, b_we, e_wr.addr, e_wr.data);
          end
        end else begin
          if (clr_cnt == 0) first_clr = int'(b_addr);
          clr_cnt++;
          model[b_addr] = '0;
          if (b_wdata !== '0 || b_we !== 4'hf) begin
            bad++;
            $display("FAIL clear_write: got addr=%0d data=%h we=%h, want data=0 we=f", b_addr, b_wdata, b_we);
          end
        end
      end
      if (tvalid && tready) begin
        bin_i = tdata[AW-1:0];
        model[bin_i] = (&model[bin_i]) ? model[bin_i] : model[bin_i] + 32'd1;
        sb.push_back(wr_t'({bin_i, model[bin_i]}));
      end
    end
  end

  task automatic send(input logic [15:0] d);
    int n = 0;
    tdata = d;
    tvalid = 1'b1;
    @(negedge clk);
    while (!tready && n < 20000) begin
      stall_cnt++;
      n++;
      @(negedge clk);
    end
    if (!tready) timeouts++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    ok = sb.size() == 0 && !busy;
  endtask

  task automatic test_reset;
    for (int i = 0; i < N; i++) begin
      mem0[i] <= '1;
      model[i] = '1;
    end
    for (int i = 0; i < 16; i++) mem1[i] <= '0;
    areset = 1'b1;
    cfg_clear = 1'b0;
    tvalid = 1'b0;
    tdata = '0;
    tvalid1 = 1'b0;
    tdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({tready, busy, b_en, b_we} !== 7'b0100000) begin
      bad++;
      $display("FAIL reset_ctrl: got tready=%b busy=%b b_en=%b we=%h, want 0 1 0 0", tready, busy, b_en, b_we);
    end
    total++;
    if (b_addr !== '0 || b_wdata !== '0) begin
      bad++;
      $display("FAIL reset_regs: got addr=%0d wdata=%h, want 0 0", b_addr, b_wdata);
    end
    total++;
    if (tready1 !== 1'b1 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_norun_clear: got tready=%b busy=%b, want 1 0", tready1, busy1);
    end
  endtask

  task automatic test_reset_sweep;
    int n = 0, nz = 0;
    clr_cnt = 0;
    areset = 1'b0;
    while (!tready && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n != N + 1) begin
      bad++;
      $display("FAIL sweep_latency: got %0d cycles, want %0d", n, N + 1);
    end
    @(posedge clk);
    #1;
    total++;
    if (clr_cnt != N || first_clr != 0) begin
      bad++;
      $display("FAIL sweep_writes: got %0d writes from %0d, want %0d from 0", clr_cnt, first_clr, N);
    end
    for (int i = 0; i < N; i++) if (mem0[i] !== '0) nz++;
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL sweep_zero: got %0d nonzero bins, want 0", nz);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    stall_cnt = 0;
    repeat (1000) send(16'd5);
    tvalid = 1'b0;
    wait_drain(ok);
    total++;
    if (!ok || timeouts != 0) begin
      bad++;
      $display("FAIL b2b_drain: got ok=%0d timeouts=%0d, want 1 0", ok, timeouts);
    end
    total++;
    if (mem0[5] !== 32'd1000) begin
      bad++;
      $display("FAIL b2b_bin5: got %0d, want 1000", mem0[5]);
    end
    total++;
    if (stall_cnt != 0) begin
      bad++;
      $display("FAIL b2b_tready: got %0d stalls, want 0", stall_cnt);
    end
  endtask

  task automatic test_forwarding;
    bit ok;
    logic [15:0] pat [6] = '{16'd7, 16'd7, 16'd9, 16'd7, 16'd9, 16'd9};
    stall_cnt = 0;
    for (int i = 0; i < 6; i++) send(pat[i]);
    tvalid = 1'b0;
    wait_drain(ok);
    total++;
    if (mem0[7] !== 32'd3 || mem0[9] !== 32'd3) begin
      bad++;
      $display("FAIL fwd_bins: got bin7=%0d bin9=%0d, want 3 3", mem0[7], mem0[9]);
    end
    total++;
    if (!ok || stall_cnt != 0) begin
      bad++;
      $display("FAIL fwd_flow: got ok=%0d stalls=%0d, want 1 0", ok, stall_cnt);
    end
  endtask

  task automatic test_saturation;
    bit ok;
    mem0[3] <= 32'hffff_fffe;
    model[3] = 32'hffff_fffe;
    @(posedge clk);
    #1;
    repeat (3) send(16'd3);
    tvalid = 1'b0;
    wait_drain(ok);
    total++;
    if (mem0[3] !== 32'hffff_ffff) begin
      bad++;
      $display("FAIL sat_bin3: got %h, want ffffffff", mem0[3]);
    end
  endtask

  task automatic test_bin_shift;
    int stalls = 0, nz = 0;
    for (int i = 0; i < 16; i++) begin
      tdata1 = 16'(i);
      tvalid1 = 1'b1;
      @(negedge clk);
      if (!tready1) stalls++;
      @(posedge clk);
      #1;
    end
    tvalid1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem1[i] !== 32'd4) begin
        bad++;
        $display("FAIL shift_bin%0d: got %0d, want 4", i, mem1[i]);
      end
    end
    for (int i = 4; i < 16; i++) if (mem1[i] !== '0) nz++;
    total++;
    if (nz != 0 || stalls != 0) begin
      bad++;
      $display("FAIL shift_rest: got %0d nonzero bins %0d stalls, want 0 0", nz, stalls);
    end
  endtask

  task automatic test_clear_stream;
    bit ok;
    int nb = 0;
    clr_cnt = 0;
    stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) send(16'($urandom) & 16'hc00f);
        tvalid = 1'b0;
      end
      begin
        repeat (10) @(posedge clk);
        #1 cfg_clear = 1'b1;
        @(posedge clk);
        #1 cfg_clear = 1'b0;
      end
    join
    wait_drain(ok);
    total++;
    if (!ok || timeouts != 0) begin
      bad++;
      $display("FAIL clr_drain: got ok=%0d timeouts=%0d, want 1 0", ok, timeouts);
    end
    total++;
    if (clr_cnt != N || stall_cnt < N) begin
      bad++;
      $display("FAIL clr_sweep: got %0d clear writes %0d stalls, want %0d and >=%0d", clr_cnt, stall_cnt, N, N);
    end
    for (int i = 0; i < N; i++) if (mem0[i] !== model[i]) nb++;
    total++;
    if (nb != 0) begin
      bad++;
      $display("FAIL clr_mem: got %0d bins differing from model, want 0", nb);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n = 0, nz = 0;
    mem0[N-5] <= 32'd7;
    model[N-5] = 32'd7;
    @(posedge clk);
    #1 cfg_clear = 1'b1;
    @(posedge clk);
    #1 cfg_clear = 1'b0;
    repeat (3000) @(posedge clk);
    #3 areset = 1'b1;
    #1;
    total++;
    if (b_en !== 1'b0 || b_we !== 4'h0) begin
      bad++;
      $display("FAIL midrst_strobe: got en=%b we=%h, want 0 0", b_en, b_we);
    end
    clr_cnt = 0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    while (!tready && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    total++;
    if (n != N + 1 || clr_cnt != N || first_clr != 0) begin
      bad++;
      $display("FAIL midrst_restart: got %0d cycles %0d writes from %0d, want %0d %0d from 0", n, clr_cnt, first_clr, N + 1, N);
    end
    for (int i = 0; i < N; i++) if (mem0[i] !== '0) nz++;
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL midrst_zero: got %0d nonzero bins, want 0", nz);
    end
  endtask

  initial begin
    test_reset;
    test_reset_sweep;
    test_back_to_back;
    test_forwarding;
    test_saturation;
    test_bin_shift;
    test_clear_stream;
    test_reset_mid_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
